// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_memwait_fsm.sv
// Data-memory wait FSM: stalls while an access is outstanding, aborts after
// MEM_TIMEOUT consecutive wait cycles and raises a sticky error.
module hazard_memwait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic dmem_req_M,
    input  logic dmem_ready,
    output logic memStall,
    output logic mem_err
);

    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    hz_state_e  state;
    logic [7:0] wait_cnt;
    logic       timeout;

    // The release happens in the same cycle ready (or the timeout) is seen.
    always_comb begin
        timeout  = (state == WAIT) && (wait_cnt == LAST_CNT) && !dmem_ready;
        memStall = ((state == RUN)  && dmem_req_M && !dmem_ready) ||
                   ((state == WAIT) && !dmem_ready && !timeout);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req_M && !dmem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (timeout) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding controls for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_EN to add saturating performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       PCSrcE,
    input  logic       ResultSrcE0,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_memwait_cyc
`endif
);

    logic memStall;
    logic lwStall;

    hazard_memwait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_memwait (
        .clk        (clk),
        .reset      (reset),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .memStall   (memStall),
        .mem_err    (mem_err)
    );

    function automatic fwd_sel_e fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
        if (wm && rdm == rs && rs != REG_ZERO)      return FWD_M;
        else if (ww && rdw == rs && rs != REG_ZERO) return FWD_W;
        else                                        return FWD_RF;
    endfunction

    // NOTE: every output gets a default first, so no path through this block
    // can leave a value held and infer a latch.
    always_comb begin
        lwStall   = ResultSrcE0 && RdE != REG_ZERO && (RdE == Rs1D || RdE == Rs2D);
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushW    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            // Redirect beats load-use; a memory stall freezes everything.
            StallF    = memStall || (lwStall && !PCSrcE);
            StallD    = StallF;
            StallE    = memStall;
            StallM    = memStall;
            FlushW    = memStall;
            FlushE    = !memStall && (lwStall || PCSrcE);
            FlushD    = !memStall && PCSrcE;
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cyc   <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cyc <= '0;
        end else begin
            if (StallF)               perf_stall_cyc   <= sat_inc(perf_stall_cyc);
            if (PCSrcE && !memStall)  perf_flush_cnt   <= sat_inc(perf_flush_cnt);
            if (memStall)             perf_memwait_cyc <= sat_inc(perf_memwait_cyc);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a cycle-level behavioural model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_hazard_unit;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       PCSrcE, ResultSrcE0, RegWriteM, RegWriteW, dmem_req_M, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
        .perf_memwait_cyc(perf_memwait_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic sf, input logic sd,
                              input logic se, input logic sm, input logic fd,
                              input logic fe, input logic fw, input logic [1:0] fa,
                              input logic [1:0] fb, input logic err);
        check({tag, ".StallF"},    32'(StallF),    32'(sf));
        check({tag, ".StallD"},    32'(StallD),    32'(sd));
        check({tag, ".StallE"},    32'(StallE),    32'(se));
        check({tag, ".StallM"},    32'(StallM),    32'(sm));
        check({tag, ".FlushD"},    32'(FlushD),    32'(fd));
        check({tag, ".FlushE"},    32'(FlushE),    32'(fe));
        check({tag, ".FlushW"},    32'(FlushW),    32'(fw));
        check({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(fa));
        check({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(fb));
        check({tag, ".mem_err"},   32'(mem_err),   32'(err));
    endtask

    // Model state: cycles the current access has already spent stalled.
    int          m_waited = 0;
    logic        m_err    = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0, m_mwait = 0;

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs == 0)                   return 2'b00;
        if (RegWriteM && RdM == rs)    return 2'b10;
        if (RegWriteW && RdW == rs)    return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        logic lw, ms, st;
        lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (dmem_ready)                         ms = 1'b0;
        else if (m_waited == 0 && !dmem_req_M)  ms = 1'b0;
        else                                    ms = (m_waited < TO - 1);
        st = ms || (lw && !PCSrcE);
        if (!reset)
            expect_out("model", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, m_err);
        else
            expect_out("model", st, st, ms, ms, !ms && PCSrcE, !ms && (lw || PCSrcE),
                       ms, fwd_model(Rs1E), fwd_model(Rs2E), m_err);
`ifdef HAZARD_PERF_EN
        check("model.perf_stall_cyc",   perf_stall_cyc,   m_stall);
        check("model.perf_flush_cnt",   perf_flush_cnt,   m_flush);
        check("model.perf_memwait_cyc", perf_memwait_cyc, m_mwait);
`endif
        // Advance the model to what the next rising edge will produce.
        if (!reset) begin
            m_waited = 0;
            m_err    = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
            m_mwait  = 0;
        end else begin
            if (st)               m_stall++;
            if (PCSrcE && !ms)    m_flush++;
            if (ms)               m_mwait++;
            if (dmem_ready || (m_waited == 0 && !dmem_req_M)) begin
                m_waited = 0;
            end else if (m_waited == TO - 1) begin
                m_waited = 0;
                m_err    = 1'b1;
            end else begin
                m_waited++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        PCSrcE = 0; ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0;
        dmem_req_M = 0; dmem_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 0;
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        smp(); expect_out("rst", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
`ifdef HAZARD_PERF_EN
        check("rst.perf_stall_cyc", perf_stall_cyc, 0);
`endif

        // Forwarding priority and x0 exclusion.
        tick(); reset = 1; RegWriteW = 1; RdW = 5;
        smp(); expect_out("fwdM", 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        tick(); RegWriteM = 0;
        smp(); expect_out("fwdW", 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        tick(); RegWriteM = 1; Rs1E = 0; Rs2E = 5;
        smp(); expect_out("fwdX0", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0);

        // Load-use, x0 destination, redirect overriding load-use.
        tick(); clr(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        smp(); expect_out("lwuse", 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        tick(); RdE = 0;
        smp(); expect_out("lwx0", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        tick(); RdE = 7; PCSrcE = 1;
        smp(); expect_out("redir", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);

        // Three wait cycles then ready, redirect pending throughout.
        tick(); clr(); dmem_req_M = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            smp(); expect_out("mwait", 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
            tick();
        end
        dmem_ready = 1;
        smp(); expect_out("mready", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);

        // Timeout: release in the fourth cycle, sticky error afterwards.
        tick(); clr(); dmem_req_M = 1;
        for (int i = 0; i < 3; i++) begin
            smp(); expect_out("tstall", 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
            tick();
        end
        smp(); expect_out("tout", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        tick(); dmem_req_M = 0;
        smp(); expect_out("terr", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        tick();
        smp(); expect_out("tsticky", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);

        // Reset in the middle of a wait.
        tick(); dmem_req_M = 1;
        smp(); expect_out("xw1", 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1);
        tick();
        smp(); expect_out("xw2", 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1);
        tick(); reset = 0;
        smp(); expect_out("xrst1", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1);
        tick();
        smp(); expect_out("xrst2", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
`ifdef HAZARD_PERF_EN
        check("xrst.perf_stall_cyc",   perf_stall_cyc,   0);
        check("xrst.perf_flush_cnt",   perf_flush_cnt,   0);
        check("xrst.perf_memwait_cyc", perf_memwait_cyc, 0);
`endif
        tick(); reset = 1; dmem_req_M = 0;
        smp(); expect_out("xrun", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        tick(); dmem_req_M = 1;
        smp(); expect_out("xnew", 1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
        tick(); dmem_ready = 1;
        smp(); expect_out("xdone", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        tick(); clr();
        smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage RV32 core. It consumes the controller's execute/memory/writeback status (PCSrcE, ResultSrcE0, RegWriteM/W) and register indices from the datapath.
- It produces stall, flush and forwarding controls, including the FlushE that the controller's D/E control register consumes.
- It owns a sequential wait FSM for variable-latency data memory, with a timeout and sticky error.

Parameters:
- MEM_TIMEOUT, 16, max consecutive cycles in WAIT before abort (2..255)
- CNT_W, 32, width of optional performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers
- RdM, RdW  in  5  memory and writeback destination registers
- PCSrcE  in  1  branch taken or jump redirect from controller
- ResultSrcE0  in  1  execute instruction is a load
- RegWriteM, RegWriteW  in  1  register write enables per stage
- dmem_req_M  in  1  memory-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  bubble the corresponding pipeline register
- ForwardAE, ForwardBE  out  2  ALU operand source select
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset: reset low at posedge sets state=RUN, wait_cnt=0, mem_err=0, and perf counters to 0.
- While reset is low: FlushD=FlushE=1; all Stall*, FlushW = 0; Forward* = 00.
- Forwarding (combinational), per operand, shown for A (B identical with Rs2E):
  - 10 if RegWriteM && RdM==Rs1E && Rs1E!=0
  - else 01 if RegWriteW && RdW==Rs1E && Rs1E!=0
  - else 00
  - M has priority over W.
- Load-use: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Redirect: PCSrcE forces FlushD=1 and FlushE=1.
- memStall (combinational) = (state==RUN && dmem_req_M && !dmem_ready) || (state==WAIT && !dmem_ready && !timeout).
- Output equations:
  - StallF = StallD = memStall || (lwStall && !PCSrcE)
  - StallE = StallM = FlushW = memStall
  - FlushE = !memStall && (lwStall || PCSrcE)
  - FlushD = !memStall && PCSrcE
- Priority, high to low: reset, memStall, redirect, load-use.
  - During memStall no flush is issued; E is frozen so a pending PCSrcE is taken on the release cycle.
  - lwStall and PCSrcE together: redirect wins and the stall is suppressed.
- Wait FSM, states RUN and WAIT:
  - RUN -> WAIT when dmem_req_M && !dmem_ready; wait_cnt <= 1.
  - WAIT && dmem_ready -> RUN; wait_cnt <= 0. Stall drops in the same cycle ready is seen (zero-cycle release).
  - WAIT && !dmem_ready: wait_cnt++.
  - timeout = (wait_cnt == MEM_TIMEOUT-1) && !dmem_ready. On timeout, stalls release that cycle, mem_err <= 1, next state RUN, wait_cnt <= 0.
  - mem_err is cleared only by reset.
  - dmem_ready asserted in RUN with no request is ignored.
- wait_cnt is 8 bits and never wraps, because timeout triggers first.
- Reset mid-WAIT returns to RUN next cycle; the pending access is abandoned.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc (CNT_W each), all saturating at all-ones.
  - perf_stall_cyc counts cycles with StallF=1.
  - perf_flush_cnt counts cycles with PCSrcE && !memStall.
  - perf_memwait_cyc counts cycles with memStall=1.
  - All reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_e: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - hz_state_e: RUN, WAIT
  - REG_ZERO = 5'd0
- One sub-module, hazard_memwait_fsm, contains state, wait_cnt, timeout and mem_err, and outputs memStall.
- Forwarding and load-use logic stay in the top level.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set Rs1E=0 with both writes active -> ForwardAE=00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0. Same with RdE=0 -> no stall.
- PCSrcE=1 with lwStall conditions also true -> FlushD=FlushE=1, StallF=StallD=0.
- dmem_req_M=1, dmem_ready low 3 cycles then high -> StallF/D/E/M and FlushW high exactly 3 cycles, low on the ready cycle. PCSrcE held high throughout -> FlushD/FlushE only on the release cycle.
- MEM_TIMEOUT=4, dmem_req_M=1, dmem_ready never asserted -> stalls release in the 4th stall cycle (timeout cycle) and mem_err=1 from the next cycle. mem_err stays 1 until reset low at a posedge.
- reset low during WAIT -> next cycle state RUN, all stalls 0, FlushD=FlushE=1 while reset stays low. With HAZARD_PERF_EN, counters read 0.
